id_ex_stage_reg: RTL and testbench
==================================

ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
REQ-001 Parameter WORD_WIDTH, default 32, datapath word width.
REQ-002 Parameter REG_FILE_DEPTH, default 4, register-index width.
REQ-003 Parameter SIGNED_IMM_WIDTH, default 24; SHIFTER_OPERAND_WIDTH, default 12.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 flush  in  1  branch taken in EX; squash the instruction being captured.
REQ-007 freeze  in  1  downstream stall; hold all state.
REQ-008 pc_in, reg1_in, reg2_in  in  WORD_WIDTH each  ID-stage PC and register-file operands.
REQ-009 dst_in, src1_in, src2_in  in  REG_FILE_DEPTH each  destination and source indices from ID.
REQ-010 signed_imm_in  in  SIGNED_IMM_WIDTH; shifter_operand_in  in  SHIFTER_OPERAND_WIDTH.
REQ-011 EX_command_in  in  4; mem_read_in, mem_write_in, WB_en_in, Imm_in, B_in, update_in, two_src_in, carry_in  in  1 each.
REQ-012 mem_dst_in  in  REG_FILE_DEPTH; mem_WB_en_in  in  1  destination/write-enable of instruction in MEM.
REQ-013 One registered *_out per REQ-008..REQ-011 field (two_src excluded), same widths.
REQ-014 valid_out  out  1  registered; EX holds a real instruction.
REQ-015 hazard  out  1  combinational RAW hazard; upstream uses it to freeze PC and IF/ID.

Function
REQ-016 src1 used = ~B_in; src2 used = two_src_in.
REQ-017 ex_hit(s) = valid_out & WB_en_out & (dst_out == s); mem_hit(s) = mem_WB_en_in & (mem_dst_in == s).
REQ-018 hazard = (src1 used & (ex_hit(src1_in) | mem_hit(src1_in))) | (src2 used & (ex_hit(src2_in) | mem_hit(src2_in))), forced 0 while flush=1.
REQ-019 Per-edge priority: flush > freeze > hazard > load.
REQ-020 flush=1: load bubble (every *_out, including data fields, = 0; valid_out=0) regardless of freeze or hazard.
REQ-021 freeze=1, flush=0: all registers hold; hazard output still evaluated from current state.
REQ-022 hazard=1, freeze=0, flush=0: load bubble as in REQ-020.
REQ-023 Otherwise: every *_out captures its *_in; valid_out=1.
REQ-024 Latency exactly one cycle from ID inputs to *_out; no combinational path from any *_in to any *_out.
REQ-025 Register-index comparisons are full REG_FILE_DEPTH-bit equality; index 0 is ordinary (no hard-wired zero register).
REQ-026 A bubble never causes a hazard (valid_out=0 masks ex_hit).

Reset
REQ-027 rst low asynchronously forces every *_out and valid_out to 0 within the same cycle, independent of clk.
REQ-028 rst deassertion takes effect at the next rising edge; first edge after release follows REQ-019.
REQ-029 rst asserted mid-stall or mid-flush discards all held state; no pending bubble or hold survives reset.

Verification
REQ-030 rst=0 mid-cycle with valid_out=1, WB_en_out=1 -> all outputs 0 immediately, before next edge.
REQ-031 Load pc_in=0x00000010, dst_in=3, WB_en_in=1, EX_command_in=4'b0010, no stall -> next edge pc_out=0x10, dst_out=3, WB_en_out=1, EX_command_out=4'b0010, valid_out=1.
REQ-032 EX holds dst_out=3, WB_en_out=1, valid_out=1; ID presents src1_in=3, B_in=0 -> hazard=1; next edge valid_out=0, WB_en_out=0; following cycle hazard=0 unless MEM matches.
REQ-033 mem_WB_en_in=1, mem_dst_in=5; ID src2_in=5, two_src_in=0 -> hazard=0; same with two_src_in=1 -> hazard=1.
REQ-034 freeze=1 for 3 cycles with changing inputs -> all outputs unchanged; freeze=1 and flush=1 same edge -> bubble loaded, valid_out=0.
REQ-035 flush=1 while hazard condition true -> hazard=0, bubble loaded; B_in=1 with src1_in matching dst_out -> hazard=0.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with RAW hazard detection against the EX and MEM stages.
// Flush and detected hazards load a zeroed bubble; freeze holds the whole stage.
module id_ex_stage_reg #(
  parameter int WORD_WIDTH            = 32,
  parameter int REG_FILE_DEPTH        = 4,
  parameter int SIGNED_IMM_WIDTH      = 24,
  parameter int SHIFTER_OPERAND_WIDTH = 12
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             freeze,
  input  logic [WORD_WIDTH-1:0]            pc_in,
  input  logic [WORD_WIDTH-1:0]            reg1_in,
  input  logic [WORD_WIDTH-1:0]            reg2_in,
  input  logic [REG_FILE_DEPTH-1:0]        dst_in,
  input  logic [REG_FILE_DEPTH-1:0]        src1_in,
  input  logic [REG_FILE_DEPTH-1:0]        src2_in,
  input  logic [SIGNED_IMM_WIDTH-1:0]      signed_imm_in,
  input  logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand_in,
  input  logic [3:0]                       EX_command_in,
  input  logic                             mem_read_in,
  input  logic                             mem_write_in,
  input  logic                             WB_en_in,
  input  logic                             Imm_in,
  input  logic                             B_in,
  input  logic                             update_in,
  input  logic                             two_src_in,
  input  logic                             carry_in,
  input  logic [REG_FILE_DEPTH-1:0]        mem_dst_in,
  input  logic                             mem_WB_en_in,
  output logic [WORD_WIDTH-1:0]            pc_out,
  output logic [WORD_WIDTH-1:0]            reg1_out,
  output logic [WORD_WIDTH-1:0]            reg2_out,
  output logic [REG_FILE_DEPTH-1:0]        dst_out,
  output logic [REG_FILE_DEPTH-1:0]        src1_out,
  output logic [REG_FILE_DEPTH-1:0]        src2_out,
  output logic [SIGNED_IMM_WIDTH-1:0]      signed_imm_out,
  output logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand_out,
  output logic [3:0]                       EX_command_out,
  output logic                             mem_read_out,
  output logic                             mem_write_out,
  output logic                             WB_en_out,
  output logic                             Imm_out,
  output logic                             B_out,
  output logic                             update_out,
  output logic                             carry_out,
  output logic                             valid_out,
  output logic                             hazard
);

  typedef struct packed {
    logic [WORD_WIDTH-1:0]            pc;
    logic [WORD_WIDTH-1:0]            reg1;
    logic [WORD_WIDTH-1:0]            reg2;
    logic [REG_FILE_DEPTH-1:0]        dst;
    logic [REG_FILE_DEPTH-1:0]        src1;
    logic [REG_FILE_DEPTH-1:0]        src2;
    logic [SIGNED_IMM_WIDTH-1:0]      signed_imm;
    logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand;
    logic [3:0]                       ex_command;
    logic                             mem_read;
    logic                             mem_write;
    logic                             wb_en;
    logic                             imm;
    logic                             b;
    logic                             update;
    logic                             carry;
    logic                             valid;
  } stage_t;

  stage_t stage_d, stage_q, load_word;
  logic   src1_used, src2_used;
  logic   ex_hit1, ex_hit2, mem_hit1, mem_hit2;

  // A bubble in EX (valid=0) can never be the producer of a hazard.
  always_comb begin
    src1_used = ~B_in;
    src2_used = two_src_in;
    ex_hit1   = stage_q.valid & stage_q.wb_en & (stage_q.dst == src1_in);
    ex_hit2   = stage_q.valid & stage_q.wb_en & (stage_q.dst == src2_in);
    mem_hit1  = mem_WB_en_in & (mem_dst_in == src1_in);
    mem_hit2  = mem_WB_en_in & (mem_dst_in == src2_in);
    hazard    = ~flush & ((src1_used & (ex_hit1 | mem_hit1)) |
                          (src2_used & (ex_hit2 | mem_hit2)));
  end

  always_comb begin
    load_word                 = '0;
    load_word.pc              = pc_in;
    load_word.reg1            = reg1_in;
    load_word.reg2            = reg2_in;
    load_word.dst             = dst_in;
    load_word.src1            = src1_in;
    load_word.src2            = src2_in;
    load_word.signed_imm      = signed_imm_in;
    load_word.shifter_operand = shifter_operand_in;
    load_word.ex_command      = EX_command_in;
    load_word.mem_read        = mem_read_in;
    load_word.mem_write       = mem_write_in;
    load_word.wb_en           = WB_en_in;
    load_word.imm             = Imm_in;
    load_word.b               = B_in;
    load_word.update          = update_in;
    load_word.carry           = carry_in;
    load_word.valid           = 1'b1;

    stage_d = stage_q;
    if (flush)       stage_d = '0;
    else if (freeze) stage_d = stage_q;
    else if (hazard) stage_d = '0;
    else             stage_d = load_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stage_q <= '0;
    else      stage_q <= stage_d;
  end

  assign pc_out              = stage_q.pc;
  assign reg1_out            = stage_q.reg1;
  assign reg2_out            = stage_q.reg2;
  assign dst_out             = stage_q.dst;
  assign src1_out            = stage_q.src1;
  assign src2_out            = stage_q.src2;
  assign signed_imm_out      = stage_q.signed_imm;
  assign shifter_operand_out = stage_q.shifter_operand;
  assign EX_command_out      = stage_q.ex_command;
  assign mem_read_out        = stage_q.mem_read;
  assign mem_write_out       = stage_q.mem_write;
  assign WB_en_out           = stage_q.wb_en;
  assign Imm_out             = stage_q.imm;
  assign B_out               = stage_q.b;
  assign update_out          = stage_q.update;
  assign carry_out           = stage_q.carry;
  assign valid_out           = stage_q.valid;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomized self-checking bench for id_ex_stage_reg, compared against a model of
// the EX slot (empty or holding the last accepted ID instruction).
module tb_id_ex_stage_reg;

  localparam int OW = 156;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [3:0]  dst;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [23:0] simm;
    logic [11:0] shop;
    logic [3:0]  cmd;
    logic        mem_read;
    logic        mem_write;
    logic        wb_en;
    logic        imm;
    logic        b;
    logic        update;
    logic        carry;
    logic        two_src;
  } in_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, freeze;
  logic [3:0]  memDst;
  logic        memWbEn;
  in_t         cur;

  logic [31:0] pc_out, reg1_out, reg2_out;
  logic [3:0]  dst_out, src1_out, src2_out, EX_command_out;
  logic [23:0] signed_imm_out;
  logic [11:0] shifter_operand_out;
  logic        mem_read_out, mem_write_out, WB_en_out, Imm_out, B_out;
  logic        update_out, carry_out, valid_out, hazard;

  int   errCount   = 0;
  int   checkCount = 0;
  bit   mValid     = 1'b0;
  in_t  mSlot      = '0;
  in_t  x;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .pc_in(cur.pc), .reg1_in(cur.reg1), .reg2_in(cur.reg2),
    .dst_in(cur.dst), .src1_in(cur.src1), .src2_in(cur.src2),
    .signed_imm_in(cur.simm), .shifter_operand_in(cur.shop),
    .EX_command_in(cur.cmd), .mem_read_in(cur.mem_read), .mem_write_in(cur.mem_write),
    .WB_en_in(cur.wb_en), .Imm_in(cur.imm), .B_in(cur.b), .update_in(cur.update),
    .two_src_in(cur.two_src), .carry_in(cur.carry),
    .mem_dst_in(memDst), .mem_WB_en_in(memWbEn),
    .pc_out(pc_out), .reg1_out(reg1_out), .reg2_out(reg2_out),
    .dst_out(dst_out), .src1_out(src1_out), .src2_out(src2_out),
    .signed_imm_out(signed_imm_out), .shifter_operand_out(shifter_operand_out),
    .EX_command_out(EX_command_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .WB_en_out(WB_en_out), .Imm_out(Imm_out),
    .B_out(B_out), .update_out(update_out), .carry_out(carry_out),
    .valid_out(valid_out), .hazard(hazard)
  );

  wire [OW-1:0] obsVec = {pc_out, reg1_out, reg2_out, dst_out, src1_out, src2_out,
                          signed_imm_out, shifter_operand_out, EX_command_out,
                          mem_read_out, mem_write_out, WB_en_out, Imm_out, B_out,
                          update_out, carry_out, valid_out};

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] expOut();
    if (!mValid) return '0;
    return {mSlot.pc, mSlot.reg1, mSlot.reg2, mSlot.dst, mSlot.src1, mSlot.src2,
            mSlot.simm, mSlot.shop, mSlot.cmd, mSlot.mem_read, mSlot.mem_write,
            mSlot.wb_en, mSlot.imm, mSlot.b, mSlot.update, mSlot.carry, 1'b1};
  endfunction

  // An instruction reads a register the EX or MEM occupant is still going to write.
  function automatic bit modelHazard(input in_t i, input bit fl, input logic [3:0] md, input bit mwb);
    bit needA, needB;
    if (fl) return 1'b0;
    needA = !i.b      && ((mValid && mSlot.wb_en && mSlot.dst == i.src1) || (mwb && md == i.src1));
    needB = i.two_src && ((mValid && mSlot.wb_en && mSlot.dst == i.src2) || (mwb && md == i.src2));
    return needA || needB;
  endfunction

  function automatic in_t randInstr();
    in_t r;
    r.pc = $urandom; r.reg1 = $urandom; r.reg2 = $urandom;
    r.dst  = 4'($urandom_range(0, 3));
    r.src1 = 4'($urandom_range(0, 3));
    r.src2 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
    r.simm = 24'($urandom); r.shop = 12'($urandom); r.cmd = 4'($urandom);
    r.mem_read = 1'($urandom); r.mem_write = 1'($urandom); r.wb_en = 1'($urandom);
    r.imm = 1'($urandom); r.b = 1'($urandom); r.update = 1'($urandom);
    r.carry = 1'($urandom); r.two_src = 1'($urandom);
    return r;
  endfunction

  task automatic applyStimulus(input in_t i, input bit fl, input bit fz, input logic [3:0] md, input bit mwb);
    cur = i; flush = fl; freeze = fz; memDst = md; memWbEn = mwb;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic runCycle(input in_t i, input bit fl, input bit fz, input logic [3:0] md,
                          input bit mwb, input int dirHaz = -1);
    bit expH;
    applyStimulus(i, fl, fz, md, mwb);
    #1;
    expH = modelHazard(i, fl, md, mwb);
    checkOutput("hazard", 256'(hazard), 256'(expH));
    if (dirHaz >= 0) checkOutput("hazard_directed", 256'(hazard), 256'(dirHaz[0]));
    @(posedge clk);
    if (fl || (!fz && expH)) mValid = 1'b0;
    else if (!fz) begin mValid = 1'b1; mSlot = i; end
    #1;
    checkOutput("outputs", 256'(obsVec), 256'(expOut()));
    @(negedge clk);
  endtask

  // Assert reset between edges, hold it across one edge, release before the next.
  task automatic midCycleReset();
    #2 rst = 1'b0;
    #1 mValid = 1'b0;
    checkOutput("async_reset", 256'(obsVec), 256'(expOut()));
    checkOutput("async_reset_valid", 256'(valid_out), 256'(0));
    @(posedge clk); #1;
    checkOutput("reset_held", 256'(obsVec), 256'(expOut()));
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus('0, 1'b0, 1'b0, 4'd0, 1'b0);
    @(negedge clk); #1;
    checkOutput("reset_state", 256'(obsVec), 256'(0));
    rst = 1'b1;
    @(negedge clk);

    // Plain load of a known instruction.
    x = '0; x.pc = 32'h10; x.dst = 4'd3; x.wb_en = 1'b1; x.cmd = 4'b0010; x.b = 1'b1;
    runCycle(x, 0, 0, 4'd0, 0, 0);
    checkOutput("pc_out", 256'(pc_out), 256'(32'h10));
    checkOutput("dst_out", 256'(dst_out), 256'(3));
    checkOutput("wb_en_out", 256'(WB_en_out), 256'(1));
    checkOutput("ex_command_out", 256'(EX_command_out), 256'(4'b0010));
    checkOutput("valid_out", 256'(valid_out), 256'(1));

    // EX-stage RAW on src1, then the bubble clears it.
    x = '0; x.src1 = 4'd3; x.pc = 32'h14;
    runCycle(x, 0, 0, 4'd0, 0, 1);
    checkOutput("bubble_valid", 256'(valid_out), 256'(0));
    checkOutput("bubble_wb_en", 256'(WB_en_out), 256'(0));
    runCycle(x, 0, 0, 4'd0, 0, 0);

    // MEM-stage match only matters when src2 is actually read.
    x = '0; x.b = 1'b1; x.src2 = 4'd5; x.two_src = 1'b0;
    runCycle(x, 0, 0, 4'd5, 1, 0);
    x.two_src = 1'b1;
    runCycle(x, 0, 0, 4'd5, 1, 1);

    // Freeze holds through changing inputs; flush beats freeze.
    runCycle(randInstr(), 0, 0, 4'd9, 0);
    for (int k = 0; k < 3; k++) runCycle(randInstr(), 0, 1, 4'($urandom), 1'($urandom));
    runCycle(randInstr(), 1, 1, 4'd0, 0);
    checkOutput("freeze_flush_valid", 256'(valid_out), 256'(0));

    // Flush masks a live hazard; B_in=1 hides src1.
    x = '0; x.dst = 4'd7; x.wb_en = 1'b1; x.b = 1'b1;
    runCycle(x, 0, 0, 4'd0, 0);
    x = '0; x.src1 = 4'd7;
    runCycle(x, 1, 0, 4'd0, 0, 0);
    x = '0; x.dst = 4'd7; x.wb_en = 1'b1; x.b = 1'b1;
    runCycle(x, 0, 0, 4'd0, 0);
    x = '0; x.src1 = 4'd7; x.b = 1'b1;
    runCycle(x, 0, 0, 4'd0, 0, 0);

    // Reset from a valid, writing instruction, then from mid-freeze.
    x = randInstr(); x.wb_en = 1'b1; x.b = 1'b1; x.two_src = 1'b0;
    runCycle(x, 0, 0, 4'd0, 0);
    midCycleReset();
    x = randInstr(); x.b = 1'b1; x.two_src = 1'b0;
    runCycle(x, 0, 0, 4'd0, 0);
    applyStimulus(randInstr(), 1'b0, 1'b1, 4'd0, 1'b0);
    midCycleReset();
    runCycle(randInstr(), 0, 0, 4'd0, 0);

    for (int n = 0; n < 400; n++) begin
      runCycle(randInstr(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
               4'($urandom_range(0, 4)), 1'($urandom));
      if ($urandom_range(0, 60) == 0) midCycleReset();
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
